// File: rtl/ram_bist_ctrl_pkg.sv
// Shared types and helpers for the March C- RAM BIST controller.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;
    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_e;
    typedef enum logic {READ, WRITE} bist_op_e;

    localparam int FAIL_CNT_W = 8;

    function automatic logic elem_down(march_elem_e e);
        return (e == E3) || (e == E4);
    endfunction

    function automatic logic elem_two_op(march_elem_e e);
        return (e != E0) && (e != E5);
    endfunction

    function automatic logic elem_wr_val(march_elem_e e);
        return (e == E1) || (e == E3);
    endfunction

    function automatic logic elem_rd_val(march_elem_e e);
        return (e == E2) || (e == E4);
    endfunction

    function automatic bist_op_e elem_first_op(march_elem_e e);
        return (e == E0) ? WRITE : READ;
    endfunction

endpackage

// File: rtl/ram_bist_ctrl_addr_gen.sv
// Up/down address counter for one march element; parks at the element's end address.
module bist_addr_gen #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_d, addr_q;
    logic              down_d, down_q;

    // Direction is latched on load so that last never depends on this cycle's control.
    assign last = down_q ? (addr_q == '0) : (addr_q == TOP);
    assign addr = addr_q;

    always_comb begin
        addr_d = addr_q;
        down_d = down_q;
        if (load) begin
            down_d = load_down;
            addr_d = load_down ? TOP : '0;
        end else if (step && !last) begin
            addr_d = down_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            down_q <= down_d;
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller for the FIFO storage RAM: sequencing, compare and results.
module ram_bist_ctrl
    import bist_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [FAIL_CNT_W-1:0] fail_count,
    output logic                  bist_en,
    output logic                  bist_wr_en,
    output logic                  bist_rd_en,
    output logic [ADDR_W-1:0]     bist_addr,
    output logic [WIDTH-1:0]      bist_wr_data,
    input  logic [WIDTH-1:0]      bist_rd_data
);

    bist_state_e state_d, state_q;
    march_elem_e elem_d, elem_q;
    bist_op_e    op_d, op_q;

    logic busy_d, busy_q, done_d, done_q, pass_d, pass_q;
    logic en_d, en_q, wr_en_d, wr_en_q, rd_en_d, rd_en_q;
    logic wr_val_d, wr_val_q;
    logic rd_v_d, rd_v_q, exp_d, exp_q;
    logic [ADDR_W-1:0]     cmp_addr_d, cmp_addr_q;
    logic [ADDR_W-1:0]     fail_addr_d, fail_addr_q;
    logic [FAIL_CNT_W-1:0] fail_cnt_d, fail_cnt_q;

    logic              ag_load, ag_down, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic              mismatch;

    bist_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ag_load),
        .load_down (ag_down),
        .step      (ag_step),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    assign mismatch = rd_v_q && (bist_rd_data != {WIDTH{exp_q}});

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        en_d        = en_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        wr_val_d    = wr_val_q;
        ag_load     = 1'b0;
        ag_down     = 1'b0;
        ag_step     = 1'b0;
        // Expected value and address travel one cycle behind the read strobe.
        rd_v_d      = rd_en_q;
        exp_d       = elem_rd_val(elem_q);
        cmp_addr_d  = ag_addr;
        fail_cnt_d  = fail_cnt_q;
        fail_addr_d = fail_addr_q;
        if (mismatch) begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
            if (fail_cnt_q == '0) fail_addr_d = cmp_addr_q;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    elem_d      = E0;
                    op_d        = WRITE;
                    ag_load     = 1'b1;
                    busy_d      = 1'b1;
                    en_d        = 1'b1;
                    wr_en_d     = 1'b1;
                    wr_val_d    = 1'b0;
                    pass_d      = 1'b0;
                    fail_cnt_d  = '0;
                    fail_addr_d = '0;
                end
            end
            RUN: begin
                if (elem_two_op(elem_q) && op_q == READ) begin
                    op_d = WRITE;
                end else if (!ag_last) begin
                    ag_step = 1'b1;
                    op_d    = elem_first_op(elem_q);
                end else if (elem_q != E5) begin
                    elem_d  = march_elem_e'(elem_q + 3'd1);
                    ag_load = 1'b1;
                    ag_down = elem_down(elem_d);
                    op_d    = elem_first_op(elem_d);
                end else begin
                    state_d = DRAIN;
                end
                if (state_d == RUN) begin
                    rd_en_d  = (op_d == READ);
                    wr_en_d  = (op_d == WRITE);
                    wr_val_d = elem_wr_val(elem_d);
                end
            end
            DRAIN: begin
                state_d = DONE;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                done_d  = 1'b1;
                pass_d  = (fail_cnt_d == '0);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            elem_q      <= E0;
            op_q        <= WRITE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            en_q        <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_val_q    <= 1'b0;
            rd_v_q      <= 1'b0;
            exp_q       <= 1'b0;
            cmp_addr_q  <= '0;
            fail_cnt_q  <= '0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            en_q        <= en_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wr_val_q    <= wr_val_d;
            rd_v_q      <= rd_v_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_addr    = fail_addr_q;
    assign fail_count   = fail_cnt_q;
    assign bist_en      = en_q;
    assign bist_wr_en   = wr_en_q;
    assign bist_rd_en   = rd_en_q;
    assign bist_addr    = ag_addr;
    assign bist_wr_data = {WIDTH{wr_val_q}};

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural RAM and injectable stuck-at faults.
module tb_ram_bist_ctrl;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 64;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, pass, bist_en, bist_wr_en, bist_rd_en;
    logic [ADDR_W-1:0] fail_addr, bist_addr;
    logic [7:0] fail_count;
    logic [WIDTH-1:0] bist_wr_data;
    logic [WIDTH-1:0] bist_rd_data = '0;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ram_bist_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_addr    (fail_addr),
        .fail_count   (fail_count),
        .bist_en      (bist_en),
        .bist_wr_en   (bist_wr_en),
        .bist_rd_en   (bist_rd_en),
        .bist_addr    (bist_addr),
        .bist_wr_data (bist_wr_data),
        .bist_rd_data (bist_rd_data)
    );

    // RAM model; the faulty cell forces one bit as it is written
    logic [WIDTH-1:0] mem [DEPTH];
    int   f_addr = -1;
    int   f_bit  = 0;
    logic f_val  = 1'b0;

    function automatic logic [WIDTH-1:0] faulty(input logic [ADDR_W-1:0] a,
                                                input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        if (int'(a) == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (bist_wr_en) mem[bist_addr] <= faulty(bist_addr, bist_wr_data);
        if (bist_rd_en) bist_rd_data <= mem[bist_addr];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    int done_cnt, done_cyc, busy_first, busy_last, wr_cnt, rd_cnt;
    logic pass1, rst_en, rst_busy;
    logic [ADDR_W-1:0] log_addr [1:100];
    logic log_rd [1:100];
    logic log_wr [1:100];
    logic log_en [1:100];
    logic [ADDR_W-1:0] exp_addr [1:80];
    logic exp_rd [1:80];

    task automatic run(input int rst_at, input int start_at);
        done_cnt = 0; done_cyc = 0; busy_first = 0; busy_last = 0;
        wr_cnt = 0; rd_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 100; k++) begin
            start = (k == start_at);
            if (busy) begin
                if (busy_first == 0) busy_first = k;
                busy_last = k;
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (bist_wr_en) wr_cnt++;
            if (bist_rd_en) rd_cnt++;
            log_addr[k] = bist_addr;
            log_rd[k]   = bist_rd_en;
            log_wr[k]   = bist_wr_en;
            log_en[k]   = bist_en;
            if (k == 1) pass1 = pass;
            if (k == rst_at) begin
                #2 reset = 1'b1;
                #1 rst_en = bist_en;
                rst_busy = busy;
                #2 reset = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int c, seq_err;
        c = 1;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int o = 0; o < ((e == 0 || e == 5) ? 1 : 2); o++) begin
                    exp_addr[c] = ADDR_W'((e == 3 || e == 4) ? DEPTH - 1 - i : i);
                    exp_rd[c]   = (e != 0) && (o == 0);
                    c++;
                end
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_pass", 64'(pass), 0);
        chk("rst_faddr", 64'(fail_addr), 0);
        chk("rst_fcnt", 64'(fail_count), 0);
        chk("rst_en", 64'(bist_en), 0);
        chk("rst_strobes", 64'({bist_wr_en, bist_rd_en}), 0);
        chk("rst_addr", 64'(bist_addr), 0);
        chk("rst_wdata", bist_wr_data, 0);

        // fault-free run
        run(0, 0);
        chk("ff_busy_first", 64'(busy_first), 1);
        chk("ff_busy_last", 64'(busy_last), 81);
        chk("ff_done_cyc", 64'(done_cyc), 82);
        chk("ff_done_cnt", 64'(done_cnt), 1);
        chk("ff_pass", 64'(pass), 1);
        chk("ff_fcnt", 64'(fail_count), 0);
        chk("ff_writes", 64'(wr_cnt), 40);
        chk("ff_reads", 64'(rd_cnt), 40);
        chk("ff_drain_en", 64'(log_en[81]), 1);
        chk("ff_drain_strb", 64'({log_wr[81], log_rd[81]}), 0);
        chk("ff_done_en", 64'(log_en[82]), 0);
        seq_err = 0;
        for (int k = 1; k <= 80; k++)
            if (log_addr[k] !== exp_addr[k] || log_rd[k] !== exp_rd[k]
                || log_wr[k] !== !exp_rd[k]) seq_err++;
        chk("ff_seq_errs", 64'(seq_err), 0);
        chk("e3_first", 64'({log_addr[41], log_rd[41]}), {61'd0, 3'd7, 1'b1} >> 0);
        chk("e3_last", 64'({log_addr[56], log_wr[56]}), 64'({3'd0, 1'b1}));
        for (int k = 73; k <= 80; k++)
            chk("e5_addr", 64'({log_addr[k], log_rd[k]}), 64'({3'(k - 73), 1'b1}));

        // stuck-at-0, bit 5, address 3
        f_addr = 3; f_bit = 5; f_val = 1'b0;
        run(0, 0);
        chk("sa0_pass_clr", 64'(pass1), 0);
        chk("sa0_pass", 64'(pass), 0);
        chk("sa0_faddr", 64'(fail_addr), 3);
        chk("sa0_fcnt", 64'(fail_count), 2);
        chk("sa0_done_cyc", 64'(done_cyc), 82);

        // stuck-at-1, bit 0, address 6
        f_addr = 6; f_bit = 0; f_val = 1'b1;
        run(0, 0);
        chk("sa1_pass", 64'(pass), 0);
        chk("sa1_faddr", 64'(fail_addr), 6);
        chk("sa1_fcnt", 64'(fail_count), 3);

        // start pulsed mid-run is ignored
        f_addr = -1;
        run(0, 20);
        chk("midst_done_cnt", 64'(done_cnt), 1);
        chk("midst_done_cyc", 64'(done_cyc), 82);
        chk("midst_pass", 64'(pass), 1);

        // reset mid-run, with a fault already logged
        f_addr = 6; f_bit = 0; f_val = 1'b1;
        run(40, 0);
        chk("mrst_en", 64'(rst_en), 0);
        chk("mrst_busy", 64'(rst_busy), 0);
        chk("mrst_done_cnt", 64'(done_cnt), 0);
        chk("mrst_fcnt", 64'(fail_count), 0);
        chk("mrst_idle_en", 64'(log_en[60]), 0);

        f_addr = -1;
        run(0, 0);
        chk("post_done_cyc", 64'(done_cyc), 82);
        chk("post_done_cnt", 64'(done_cnt), 1);
        chk("post_pass", 64'(pass), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
